// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative encryption engine.
// Provides the state/byte types, the controller state enum, the round-constant
// values, the S-box, xtime and the column-major byte helper. It also provides
// the SubBytes/ShiftRows/MixColumns round-step functions used by the datapath.
// State layout: byte i (FIPS-197 order) sits at bits [127-8i -: 8], and
// byte i = row (i % 4), column (i / 4).
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [7:0]   byte_t;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} ctrl_state_e;

   localparam byte_t RCON_INIT = 8'h01;
   localparam byte_t RCON_POLY = 8'h1B;

   // S-box flattened row-major: entry 0x00 occupies the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic byte_t sbox(input byte_t b);
      return SBOX_TBL[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic byte_t st_byte(input state_t s, input int r, input int c);
      return s[127 - 8*(r + 4*c) -: 8];
   endfunction

   function automatic state_t sub_bytes(input state_t s);
      state_t o;
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
      return o;
   endfunction

   // Row r rotates left by r columns.
   function automatic state_t shift_rows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = st_byte(s, r, (c + r) % 4);
      return o;
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t o;
      byte_t  a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = st_byte(s, 0, c);
         a1 = st_byte(s, 1, c);
         a2 = st_byte(s, 2, c);
         a3 = st_byte(s, 3, c);
         o[127 - 8*(4*c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[127 - 8*(1 + 4*c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[127 - 8*(2 + 4*c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[127 - 8*(3 + 4*c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step (combinational).
// Ports:
//   rk_in  [127:0]  current round key {w0,w1,w2,w3}
//   rcon   [7:0]    round constant for this step
//   rk_out [127:0]  next round key {w4,w5,w6,w7}
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_in,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_out
);

   logic [31:0] w0, w1, w2, w3, rot_w, sub_w, w4, w5, w6, w7;

   always_comb begin
      w0     = rk_in[127:96];
      w1     = rk_in[95:64];
      w2     = rk_in[63:32];
      w3     = rk_in[31:0];
      rot_w  = {w3[23:0], w3[31:24]};
      sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      w4     = w0 ^ sub_w ^ {rcon, 24'h0};
      w5     = w4 ^ w1;
      w6     = w5 ^ w2;
      w7     = w6 ^ w3;
      rk_out = {w4, w5, w6, w7};
   end

endmodule

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption engine: one full round per clock over a single
// 128-bit state register, with round keys generated on the fly.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready plaintext+key handshake (in_ready = FSM in IDLE)
//   plaintext, key    input block and cipher key (FIPS-197 byte order)
//   out_valid/out_ready ciphertext handshake; result held until accepted
//   ciphertext        result block, kept until the next FINAL or reset
//   busy              FSM not in IDLE
//   round_idx         current round number, 0 while idle
module aes_enc_iter_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int DATA_W     = 128
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] plaintext,
   input  logic [DATA_W-1:0] key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ciphertext,
   output logic              busy,
   output logic [3:0]        round_idx
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   ctrl_state_e fsm_q, fsm_d;
   state_t      state_reg_q, state_reg_d;
   state_t      rk_q, rk_d;
   state_t      ct_q, ct_d;
   byte_t       rcon_q, rcon_d;
   logic [3:0]  round_q, round_d;
   logic        ov_q, ov_d;

   state_t rk_next, sr_out, mc_out, round_out;

   aes_key_step u_key_step (
      .rk_in  (rk_q),
      .rcon   (rcon_q),
      .rk_out (rk_next)
   );

   // Round datapath; the last round skips MixColumns.
   always_comb begin
      sr_out    = shift_rows(sub_bytes(state_reg_q));
      mc_out    = mix_columns(sr_out);
      round_out = ((fsm_q == FINAL) ? sr_out : mc_out) ^ rk_next;
   end

   always_comb begin
      fsm_d       = fsm_q;
      state_reg_d = state_reg_q;
      rk_d        = rk_q;
      rcon_d      = rcon_q;
      round_d     = round_q;
      ct_d        = ct_q;
      ov_d        = ov_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_reg_d = plaintext ^ key;
               rk_d        = key;
               rcon_d      = RCON_INIT;
               round_d     = 4'd1;
               fsm_d       = ROUND;
            end
         end
         ROUND: begin
            state_reg_d = round_out;
            rk_d        = rk_next;
            rcon_d      = xtime(rcon_q);
            round_d     = round_q + 4'd1;
            if (round_q == LAST_ROUND) fsm_d = FINAL;
         end
         FINAL: begin
            state_reg_d = round_out;
            rk_d        = rk_next;
            rcon_d      = xtime(rcon_q);
            ct_d        = round_out;
            ov_d        = 1'b1;
            fsm_d       = DONE;
         end
         DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               round_d = 4'd0;
               fsm_d   = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_reg_q <= '0;
         rk_q        <= '0;
         ct_q        <= '0;
         rcon_q      <= RCON_INIT;
         round_q     <= 4'd0;
         ov_q        <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_reg_q <= state_reg_d;
         rk_q        <= rk_d;
         ct_q        <= ct_d;
         rcon_q      <= rcon_d;
         round_q     <= round_d;
         ov_q        <= ov_d;
      end
   end

   assign in_ready   = (fsm_q == IDLE);
   assign busy       = (fsm_q != IDLE);
   assign out_valid  = ov_q;
   assign ciphertext = ct_q;
   assign round_idx  = round_q;

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Scoreboard bench for aes_enc_iter_ctrl: the driver pushes the expected
// ciphertext at every acceptance; the monitor pops and compares on every
// output handshake.
module tb_aes_enc_iter_ctrl;

   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] plaintext, key, ciphertext;
   logic [3:0]   round_idx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ov_cycles = 0;
   logic [127:0] exp_q[$];

   aes_enc_iter_ctrl #(.NUM_ROUNDS(10), .DATA_W(128)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy),
      .round_idx  (round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a block and wait (bounded) for acceptance; acc = edge count at acceptance.
   task automatic send(input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] ex, output int acc);
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      for (int i = 0; i < 100 && !in_ready; i++) step();
      chk("accept_wait", {127'd0, in_ready}, 128'd1);
      exp_q.push_back(ex);
      step();
      acc      = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int i = 0; i < 40 && !out_valid; i++) step();
      chk("out_valid_wait", {127'd0, out_valid}, 128'd1);
   endtask

   // Monitor: compare on each output handshake.
   always @(negedge clk) begin
      logic [127:0] e;
      if (!rst && out_valid) ov_cycles++;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output got=%h expected=none", ciphertext);
         end else begin
            e = exp_q.pop_front();
            chk("ciphertext", ciphertext, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, n, acc;
      int acc_t[2];
      int ov_before;

      rst = 1'b1; in_valid = 1'b0; plaintext = '0; key = '0; out_ready = 1'b1;
      step(); step();
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_round_idx", {124'd0, round_idx}, 128'd0);
      chk("rst_ciphertext", ciphertext, 128'd0);
      chk("rst_rcon", {120'd0, dut.rcon_q}, 128'h01);
      chk("rst_state_reg", dut.state_reg_q, 128'd0);
      chk("rst_rk", dut.rk_q, 128'd0);
      rst = 1'b0;
      step();

      // App. B with latency and first-round internals
      send(PT_B, K_B, CT_B, a0);
      chk("b_round_idx_e0", {124'd0, round_idx}, 128'd1);
      chk("b_busy", {127'd0, busy}, 128'd1);
      chk("b_in_ready_low", {127'd0, in_ready}, 128'd0);
      step();
      chk("b_rk_e1", dut.rk_q, 128'ha0fafe1788542cb123a339392a6c7605);
      chk("b_state_e1", dut.state_reg_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
      n = 1;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk("b_latency", n, 10);
      step();
      chk("b_in_ready_after", {127'd0, in_ready}, 128'd1);
      chk("b_out_valid_after", {127'd0, out_valid}, 128'd0);
      chk("b_round_idx_after", {124'd0, round_idx}, 128'd0);

      // App. C.1
      send(PT_C, K_C, CT_C, a0);
      wait_out();
      step();

      // Backpressure
      out_ready = 1'b0;
      send(PT_B, K_B, CT_B, a0);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
         chk("bp_ciphertext", ciphertext, CT_B);
         chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_out_valid_drop", {127'd0, out_valid}, 128'd0);
      chk("bp_in_ready_back", {127'd0, in_ready}, 128'd1);

      // in_valid held while busy with alternating blocks
      acc = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 60 && acc < 2; i++) begin
         plaintext = (i % 2 == 0) ? PT_B : PT_C;
         key       = (i % 2 == 0) ? K_B : K_C;
         if (in_ready) begin
            exp_q.push_back((i % 2 == 0) ? CT_B : CT_C);
            acc_t[acc] = cyc;
            acc++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("busy_accept_count", acc, 2);
      chk("busy_accept_gap", acc_t[1] - acc_t[0], 12);
      wait_out();
      step();

      // Reset in the middle of a block
      send(PT_B, K_B, CT_B, a0);
      for (int i = 0; i < 40 && round_idx != 4'd5; i++) step();
      chk("mid_round_idx", {124'd0, round_idx}, 128'd5);
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      chk("mid_out_valid", {127'd0, out_valid}, 128'd0);
      chk("mid_busy", {127'd0, busy}, 128'd0);
      chk("mid_in_ready", {127'd0, in_ready}, 128'd1);
      chk("mid_ciphertext", ciphertext, 128'd0);
      chk("mid_round_idx_clr", {124'd0, round_idx}, 128'd0);
      send(PT_C, K_C, CT_C, a0);
      wait_out();
      step();

      // Back-to-back
      ov_before = ov_cycles;
      send(PT_B, K_B, CT_B, a0);
      send(PT_C, K_C, CT_C, a1);
      chk("b2b_accept_gap", a1 - a0, 12);
      wait_out();
      step();
      chk("b2b_out_valid_cycles", ov_cycles - ov_before, 2);

      step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_enc_iter_ctrl.md
Name: aes_enc_iter_ctrl

Overview:
- Iterative AES-128 encryption engine: one full round per clock over a single 128-bit state register.
- Sequences the existing round-step modules (SubBytes, ShiftRows, MixColumns, AddRoundKey) and generates round keys on the fly.
- Sits between the host-side plaintext/key source and the ciphertext sink, with valid/ready handshakes on both sides.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; 10 for AES-128; legal range 2..14.
- DATA_W, 128, state and key width; fixed at 128 (AES block).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext and key are valid.
- in_ready  output  1  engine can accept a block.
- plaintext  input  128  input block, FIPS-197 byte order (byte 0 = bits 127:120).
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  sink accepts the ciphertext.
- ciphertext  output  128  result block.
- busy  output  1  high in any state other than IDLE.
- round_idx  output  4  current round number (debug); 0 while IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, busy=0, round_idx=0, ciphertext=0, state_reg=0, rk_reg=0, rcon_reg=8'h01; FSM enters IDLE.
- States are IDLE, ROUND, FINAL and DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: state_reg <= plaintext ^ key (round-0 AddRoundKey), rk_reg <= key, rcon_reg <= 8'h01, round_idx <= 1.
  - Next state is ROUND, or FINAL if NUM_ROUNDS==1+0 is never legal.
- ROUND, rounds 1..NUM_ROUNDS-1, one cycle each:
  - rk_next = aes_key_step(rk_reg, rcon_reg).
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk_next).
  - rk_reg <= rk_next; rcon_reg <= xtime(rcon_reg), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0).
  - round_idx increments; when round_idx==NUM_ROUNDS-1, go to FINAL.
- FINAL, one cycle: the same as ROUND but without MixColumns. The result is loaded into ciphertext, out_valid <= 1, and the FSM goes to DONE.
- DONE: ciphertext and out_valid are held stable until out_ready. On out_valid&&out_ready: out_valid <= 0, FSM goes to IDLE, round_idx <= 0.
- Latency:
  - Acceptance edge E0; out_valid is first high after edge E(NUM_ROUNDS), i.e. 10 cycles for AES-128.
  - Minimum initiation interval is NUM_ROUNDS+2 cycles: in_ready is low in DONE, and out_ready is sampled in DONE.
- in_ready = (FSM==IDLE), combinational from the state register only. There is no combinational path from in_valid or out_ready to any output.
- in_valid while busy is ignored; plaintext and key are sampled only at acceptance and may change afterwards.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation (any state) aborts the block and returns all registers to their reset values next edge. No partial ciphertext is emitted.
- The rcon sequence seen by rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36; it wraps only via reset or a new acceptance.
- ciphertext is not cleared on handshake; it retains its last value until the next FINAL or rst.

Decomposition:
- Shared package aes_pkg:
  - state_t (logic [127:0]), byte_t.
  - ctrl_state_e enum {IDLE, ROUND, FINAL, DONE}.
  - RCON_INIT=8'h01 and RCON_POLY=8'h1B constants.
  - xtime() function.
  - Byte-indexing helper for column-major state.
- One sub-module, aes_key_step (combinational): rk_in[127:0], rcon[7:0] -> rk_out[127:0].
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; each following word is the previous word xor the corresponding old word.
  - Reuses the existing S-box.
- Round datapath instances the existing SubBytes, ShiftRows, MixColumns and AddRoundKey modules. The FINAL bypass is a 2:1 mux around MixColumns, selected by the FSM.

Test Plan:
- FIPS-197 App. B: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1.
  - ciphertext=3925841d02dc09fbdc118597196a0b32; out_valid rises exactly 10 cycles after acceptance.
  - After E1: internal rk=a0fafe1788542cb123a339392a6c7605, state=a49c7ff2689f352b6b5bea43026a5049.
- FIPS-197 App. C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: run App. B with out_ready=0 for 5 cycles after out_valid.
  - out_valid and ciphertext are stable across those cycles; in_ready=0 throughout.
  - The handshake completes on the first out_ready=1 edge; in_ready=1 the next cycle.
- Busy input: hold in_valid=1 with alternating pt/key every cycle during the App. B run.
  - Only the first block is accepted; the result is still 3925841d...0b32.
  - The second block is accepted in the first IDLE cycle.
- Reset mid-op: assert rst for 1 cycle at round_idx=5.
  - Next cycle: out_valid=0, busy=0, in_ready=1, ciphertext=0.
  - A subsequent App. C.1 block gives 69c4e0d8...c55a.
- Back-to-back: App. B then App. C.1 with out_ready=1.
  - Two correct results; acceptance edges are 12 cycles apart; no out_valid glitch between them.
